// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer with press/release/long-press strobes.
// Each channel is fully independent and drives its own LED.
module key_debounce_multi #(
    parameter int N_KEYS      = 4,
    parameter int DB_CYCLES   = 1_000_000,
    parameter int LONG_CYCLES = 50_000_000,
    parameter int LED_MODE    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_deb,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] led
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int LG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);
    localparam logic [LG_W-1:0] LG_MAX = LG_W'(LONG_CYCLES - 1);
    localparam logic [LG_W-1:0] LG_PRE = LG_W'(LONG_CYCLES - 2);
    localparam logic [LG_W-1:0] LG_ONE = LG_W'(1);

    // s0/s1 form the synchroniser, s2 is the reference for edge detection
    logic [N_KEYS-1:0] r_s0;
    logic [N_KEYS-1:0] r_s1;
    logic [N_KEYS-1:0] r_s2;

    // Three-flop sample chain for all channels; idle level is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0 <= '1;
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s0 <= key;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch

        logic [DB_W-1:0] r_db_cnt;
        logic [LG_W-1:0] r_lg_cnt;
        logic            r_key_deb;
        logic            r_deb_d;
        logic            r_press;
        logic            r_release;
        logic            r_long;
        logic            r_led;

        logic            w_edge;
        logic            w_db_full;
        logic            w_lg_full;
        logic            w_lg_pre;

        assign w_edge    = r_s1[g] ^ r_s2[g];
        assign w_db_full = (r_db_cnt == DB_MAX);
        assign w_lg_full = (r_lg_cnt == LG_MAX);
        assign w_lg_pre  = (r_lg_cnt == LG_PRE);

        // Stability window: any sampled change restarts it, saturates at full
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_db_cnt <= '0;
            end else if (w_edge) begin
                r_db_cnt <= '0;
            end else if (!w_db_full) begin
                r_db_cnt <= r_db_cnt + DB_ONE;
            end
        end

        // Accept the sampled level once it has been stable for the full window
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_key_deb <= 1'b1;
            end else if (w_db_full && !w_edge) begin
                r_key_deb <= r_s2[g];
            end
        end

        // Delayed debounced level and edge strobes derived from it
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_deb_d   <= 1'b1;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_deb_d   <= r_key_deb;
                r_press   <= r_deb_d & ~r_key_deb;
                r_release <= ~r_deb_d & r_key_deb;
            end
        end

        // Pressed-time counter: cleared while released, saturates at the top
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_lg_cnt <= '0;
            end else if (r_key_deb) begin
                r_lg_cnt <= '0;
            end else if (!w_lg_full) begin
                r_lg_cnt <= r_lg_cnt + LG_ONE;
            end
        end

        // Long-press strobe fires only on the step into the saturated value
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_long <= 1'b0;
            end else begin
                r_long <= ~r_key_deb & w_lg_pre;
            end
        end

        // LED behaviour selected at build time
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_led <= 1'b0;
            end else if (LED_MODE == 1) begin
                r_led <= ~r_key_deb;
            end else if (LED_MODE == 2) begin
                if (r_long) begin
                    r_led <= ~r_led;
                end
            end else begin
                if (r_press) begin
                    r_led <= ~r_led;
                end
            end
        end

        assign key_deb[g]       = r_key_deb;
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_release;
        assign long_pulse[g]    = r_long;
        assign led[g]           = r_led;

    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: three instances (one per LED mode)
// compared cycle by cycle against a window-based reference model.
module tb_key_debounce_multi;

    localparam int NK   = 2;
    localparam int DB   = 8;
    localparam int LONG = 32;

    typedef struct packed {
        logic [1:0]      kd;
        logic [1:0]      pp;
        logic [1:0]      rp;
        logic [1:0]      lp;
        logic [2:0][1:0] ld;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [NK-1:0] key;
    logic [NK-1:0] kd [3];
    logic [NK-1:0] pp [3];
    logic [NK-1:0] rp [3];
    logic [NK-1:0] lp [3];
    logic [NK-1:0] ld [3];

    int   n_cmp;
    int   n_bad;
    int   cyc;
    exp_t sbq [$];

    for (genvar m = 0; m < 3; m++) begin : g_dut
        key_debounce_multi #(
            .N_KEYS(NK),
            .DB_CYCLES(DB),
            .LONG_CYCLES(LONG),
            .LED_MODE(m)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .key(key),
            .key_deb(kd[m]),
            .press_pulse(pp[m]),
            .release_pulse(rp[m]),
            .long_pulse(lp[m]),
            .led(ld[m])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string nm, int d, logic [1:0] act, logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%b want=%b",
                     nm, d, cyc, act, exp);
        end
    endtask

    // Reference model. h[i][j] is the raw key sampled j edges ago.
    // The debounced level takes the raw value once the samples that
    // are 2..DB+2 edges old all agree; events follow one edge later.
    bit h    [NK][DB+3];
    bit deb  [NK];
    bit deb1 [NK];
    bit pp_p [NK];
    bit lp_p [NK];
    bit l0   [NK];
    bit l1   [NK];
    bit l2   [NK];
    int run  [NK];

    always @(posedge clk) begin : model
        exp_t e;
        bit   stable;
        bit   np;
        bit   nr;
        bit   nl;
        e = '0;
        cyc++;
        if (rst) begin
            for (int i = 0; i < NK; i++) begin
                for (int j = 0; j < DB + 3; j++) h[i][j] = 1'b1;
                deb[i]  = 1'b1;
                deb1[i] = 1'b1;
                run[i]  = 0;
                pp_p[i] = 1'b0;
                lp_p[i] = 1'b0;
                l0[i]   = 1'b0;
                l1[i]   = 1'b0;
                l2[i]   = 1'b0;
            end
        end else begin
            for (int i = 0; i < NK; i++) begin
                for (int j = DB + 2; j > 0; j--) h[i][j] = h[i][j-1];
                h[i][0] = key[i];
                np = !deb[i] && deb1[i];
                nr = deb[i] && !deb1[i];
                run[i] = deb[i] ? 0 : run[i] + 1;
                nl = (run[i] == LONG - 1);
                l0[i] = l0[i] ^ pp_p[i];
                l1[i] = !deb[i];
                l2[i] = l2[i] ^ lp_p[i];
                pp_p[i] = np;
                lp_p[i] = nl;
                stable = 1'b1;
                for (int j = 3; j <= DB + 2; j++)
                    if (h[i][j] != h[i][2]) stable = 1'b0;
                deb1[i] = deb[i];
                if (stable) deb[i] = h[i][2];
                e.pp[i] = np;
                e.rp[i] = nr;
                e.lp[i] = nl;
            end
        end
        for (int i = 0; i < NK; i++) begin
            e.kd[i]    = deb[i];
            e.ld[0][i] = l0[i];
            e.ld[1][i] = l1[i];
            e.ld[2][i] = l2[i];
        end
        sbq.push_back(e);
    end

    // Monitor: one expected record per clock, checked mid-cycle
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty cyc=%0d got=0 entries want>=1", cyc);
        end else begin
            e = sbq.pop_front();
            for (int d = 0; d < 3; d++) begin
                check("key_deb", d, kd[d], e.kd);
                check("press", d, pp[d], e.pp);
                check("release", d, rp[d], e.rp);
                check("long", d, lp[d], e.lp);
                check("led", d, ld[d], e.ld[d]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    // Assert reset and confirm outputs clear without waiting for a clock
    task automatic pulse_rst(int n);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_key_deb", d, kd[d], 2'b11);
            check("rst_press", d, pp[d], 2'b00);
            check("rst_release", d, rp[d], 2'b00);
            check("rst_long", d, lp[d], 2'b00);
            check("rst_led", d, ld[d], 2'b00);
        end
        ticks(n);
        rst = 1'b0;
    endtask

    int hold [NK];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst   = 1'b1;
        key   = '1;
        ticks(3);
        rst = 1'b0;
        ticks(20);

        // clean press and release on key 0
        key[0] = 1'b0;
        ticks(40);
        key[0] = 1'b1;
        ticks(40);

        // bouncing key 0, then settled low
        for (int b = 0; b < 40; b++) begin
            if (b % 3 == 0) key[0] = ~key[0];
            tick();
        end
        key[0] = 1'b0;
        ticks(30);
        key[0] = 1'b1;
        ticks(30);

        // long hold on key 1
        key[1] = 1'b0;
        ticks(60);
        key[1] = 1'b1;
        ticks(30);

        // short hold on key 1
        key[1] = 1'b0;
        ticks(20);
        key[1] = 1'b1;
        ticks(30);

        // both keys fall together
        key = 2'b00;
        ticks(30);
        key = 2'b11;
        ticks(30);

        // reset in the middle of a debounce window
        key[0] = 1'b0;
        ticks(8);
        pulse_rst(3);
        ticks(40);
        key[0] = 1'b1;
        ticks(30);

        // randomized hold lengths, short bounces and occasional reset
        for (int i = 0; i < NK; i++) hold[i] = $urandom_range(5, 40);
        for (int t = 0; t < 4000; t++) begin
            for (int i = 0; i < NK; i++) begin
                if (hold[i] == 0) begin
                    key[i] = ~key[i];
                    if ($urandom_range(0, 3) == 0)
                        hold[i] = $urandom_range(1, 4);
                    else
                        hold[i] = $urandom_range(5, 60);
                end else begin
                    hold[i]--;
                end
            end
            if ($urandom_range(0, 599) == 0)
                pulse_rst($urandom_range(1, 3));
            else
                tick();
        end
        key = '1;
        ticks(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
KEY_DEBOUNCE_MULTI -- requirements
Module: key_debounce_multi

Interface
REQ-001 SHALL provide parameter N_KEYS, default 4, number of independent key channels (1..32).
REQ-002 SHALL provide parameter DB_CYCLES, default 1_000_000, stable-time window in clk cycles (>=2; 20 ms at 50 MHz).
REQ-003 SHALL provide parameter LONG_CYCLES, default 50_000_000, debounced-pressed time for a long press (>=2).
REQ-004 SHALL provide parameter LED_MODE, default 0, LED behaviour: 0 = toggle on press, 1 = follow pressed level, 2 = toggle on long press.
REQ-005 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port key, input, N_KEYS, raw asynchronous keys, active-low (idle 1).
REQ-008 SHALL have port key_deb, output, N_KEYS, debounced key level, same polarity as key.
REQ-009 SHALL have port press_pulse, output, N_KEYS, one-cycle strobe on debounced 1->0.
REQ-010 SHALL have port release_pulse, output, N_KEYS, one-cycle strobe on debounced 0->1.
REQ-011 SHALL have port long_pulse, output, N_KEYS, one-cycle strobe when the pressed time reaches LONG_CYCLES.
REQ-012 SHALL have port led, output, N_KEYS, per-channel LED drive per LED_MODE.

Function (per channel i; channels fully independent, no shared state)
REQ-013 SHALL sample key[i] through three flops s0->s1->s2; s0,s1 are the synchroniser, edge = s1 != s2.
REQ-014 SHALL keep a debounce counter, width ceil(log2(DB_CYCLES)): edge -> 0; else below DB_CYCLES-1 -> +1; else hold at DB_CYCLES-1 (saturate, never wrap).
REQ-015 SHALL load key_deb[i] <= s2 on any cycle with counter == DB_CYCLES-1 and no edge.
REQ-016 SHALL change key_deb on the (DB_CYCLES+3)th rising edge after a key change, counting the first edge that samples the new level as edge 1.
REQ-017 SHALL leave key_deb unchanged for any key level held for fewer than DB_CYCLES-1 cycles; each bounce restarts the window.
REQ-018 SHALL register press_pulse/release_pulse from key_deb and its one-cycle-delayed copy, high exactly one cycle, one cycle after the key_deb change.
REQ-019 SHALL keep a long counter, width ceil(log2(LONG_CYCLES)): key_deb==1 -> 0; key_deb==0 and below LONG_CYCLES-1 -> +1; at LONG_CYCLES-1 -> hold.
REQ-020 SHALL assert long_pulse for one cycle on the edge where the long counter enters LONG_CYCLES-1; at most one long_pulse per press.
REQ-021 SHALL not assert long_pulse if the key is released before the long counter reaches LONG_CYCLES-1; release_pulse still fires.
REQ-022 LED_MODE 0: led[i] SHALL toggle on the edge after press_pulse[i] is high.
REQ-022a LED_MODE 1: led[i] SHALL equal the registered ~key_deb[i].
REQ-022b LED_MODE 2: led[i] SHALL toggle on the edge after long_pulse[i] is high.
REQ-023 SHALL never assert press_pulse and release_pulse together on one channel; multiple channels MAY pulse in the same cycle.

Reset
REQ-024 On rst high, s0/s1/s2 and key_deb SHALL go to all-ones, both counters to 0, all pulses to 0, led to 0, asynchronously.
REQ-025 Reset asserted mid-press or mid-count SHALL abort that operation; no pulse SHALL be generated by the deassertion of reset itself.
REQ-026 After rst release with key held low, the press SHALL be detected as a normal press after DB_CYCLES+3 edges.

Verification (N_KEYS=2, DB_CYCLES=8, LONG_CYCLES=32)
REQ-027 key[0] 1->0 clean -> key_deb[0]=0 at edge 11, press_pulse[0] high only at edge 12, led[0] 0->1 at edge 13 (LED_MODE 0).
REQ-028 key[0] bounces 0/1 every 3 cycles for 40 cycles then stays 0 -> single press_pulse, 11 edges after the last transition, no pulse during bounce.
REQ-029 key[1] held low 60 cycles -> exactly one long_pulse[1], 31 edges after key_deb[1] falls; release -> one release_pulse[1].
REQ-030 key[1] held low for 20 cycles only -> press_pulse and release_pulse, no long_pulse.
REQ-031 key[0] and key[1] fall on the same edge -> both press_pulse bits high in the same cycle.
REQ-032 rst pulsed while key[0] low and counter = 5 -> all outputs reset immediately; no pulse at release; press re-detected 11 edges after release.
